// File: rtl/sensor_fifo_pkg.sv
// Shared constants, frame type and width helpers for the sensor frame FIFO.
package sensor_fifo_pkg;
  localparam int N_CH_DEF  = 3;
  localparam int W_DEF     = 12;
  localparam int DEPTH_DEF = 4;
  localparam int DELAY_DEF = 3;
  localparam int HOLD_DEF  = 63;
  localparam int FRAME_W   = N_CH_DEF * W_DEF;

  typedef logic [FRAME_W-1:0] frame_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/sensor_frame_fifo_core.sv
// First-word fall-through frame FIFO; drops the incoming frame when full unless
// a pop happens on the same edge.
module frame_fifo_core
  import sensor_fifo_pkg::*;
#(
  parameter int DW    = FRAME_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    push,
  input  logic [DW-1:0]           push_data,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [DW-1:0]           frame_data,
  output logic [cnt_w(DEPTH)-1:0] fill_level,
  output logic                    overflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, do_push;

  assign frame_valid = (fill_level != '0);
  assign full        = (fill_level == CW'(DEPTH));
  assign pop         = frame_valid & frame_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_push     = push & (~full | pop);
  assign frame_data  = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push & full & ~pop;
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   fill_level <= fill_level + CW'(1);
        2'b01:   fill_level <= fill_level - CW'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end
endmodule

// File: rtl/sensor_frame_fifo.sv
// Sensor power-up hold, delayed frame capture and frame FIFO.
// Optional SENSOR_FIFO_STATS_EN adds a saturating overflow counter port.
module sensor_frame_fifo
  import sensor_fifo_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int W           = W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int DELAY       = DELAY_DEF,
  parameter int HOLD_CYCLES = HOLD_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ce,
  input  logic                    round_done,
  input  logic [N_CH*W-1:0]       ch_data,
  output logic                    sensor_rst_n,
  output logic [N_CH*W-1:0]       latest,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [N_CH*W-1:0]       frame_data,
  output logic [cnt_w(DEPTH)-1:0] fill_level,
  output logic                    overflow
`ifdef SENSOR_FIFO_STATS_EN
  ,output logic [15:0]            ovf_count
`endif
);
  logic [15:0]    hold_cnt, hold_nxt;
  logic [DELAY-1:0] dly;
  logic [DELAY:0]   dly_ext;
  logic           capture;

  assign hold_nxt = hold_cnt + 16'd1;
  // round_done is masked until the sensors are released.
  assign dly_ext  = {dly, round_done & sensor_rst_n};
  assign capture  = ce & dly[DELAY-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_cnt     <= '0;
      sensor_rst_n <= 1'b0;
      dly          <= '0;
      latest       <= '0;
    end else if (ce) begin
      if (!sensor_rst_n) begin
        hold_cnt <= hold_nxt;
        if (hold_nxt == 16'(HOLD_CYCLES)) sensor_rst_n <= 1'b1;
      end
      dly <= dly_ext[DELAY-1:0];
      if (capture) latest <= ch_data;
    end
  end

  frame_fifo_core #(.DW(N_CH*W), .DEPTH(DEPTH)) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push       (capture),
    .push_data  (ch_data),
    .frame_ready(frame_ready),
    .frame_valid(frame_valid),
    .frame_data (frame_data),
    .fill_level (fill_level),
    .overflow   (overflow)
  );

`ifdef SENSOR_FIFO_STATS_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                             ovf_count <= '0;
    else if (overflow && ovf_count != '1) ovf_count <= ovf_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sensor_frame_fifo.sv
// Bench for sensor_frame_fifo: queue-based reference model checked every cycle,
// plus directed literal checks.
module tb_sensor_frame_fifo;
  import sensor_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int DELAY = 3;
  localparam int HOLD  = 63;

  logic       CLK = 0, RST = 0, ce = 0, round_done = 0, frame_ready = 0;
  frame_t     ch_data = '0;
  logic       sensor_rst_n, frame_valid, overflow;
  frame_t     latest, frame_data;
  logic [2:0] fill_level;
`ifdef SENSOR_FIFO_STATS_EN
  logic [15:0] ovf_count;
`endif

  always #5 CLK = ~CLK;

  sensor_frame_fifo #(.N_CH(3), .W(12), .DEPTH(DEPTH), .DELAY(DELAY), .HOLD_CYCLES(HOLD)) dut (
    .CLK(CLK), .RST(RST), .ce(ce), .round_done(round_done), .ch_data(ch_data),
    .sensor_rst_n(sensor_rst_n), .latest(latest), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data), .fill_level(fill_level),
    .overflow(overflow)
`ifdef SENSOR_FIFO_STATS_EN
    , .ovf_count(ovf_count)
`endif
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  frame_t frames [10] = '{36'h001_002_003, 36'h011_012_013, 36'h021_022_023, 36'h031_032_033,
                          36'h041_042_043, 36'h051_052_053, 36'h061_062_063, 36'h071_072_073,
                          36'h081_082_083, 36'h091_092_093};

  // Reference model: ce tick numbering, pending capture ticks and a frame queue.
  int     t_ce = 0;
  bit     rel = 0, m_ovf = 0, m_pop, m_push;
  frame_t m_latest = '0;
  frame_t q[$];
  int     pend[$];
  int     m_ovfc = 0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      t_ce = 0; rel = 0; m_latest = '0; m_ovf = 0; m_ovfc = 0;
      q.delete(); pend.delete();
    end else begin
      m_pop  = (q.size() > 0) && frame_ready;
      m_push = 0;
      m_ovf  = 0;
      if (ce) begin
        t_ce++;
        if (pend.size() > 0 && pend[0] == t_ce) begin
          void'(pend.pop_front());
          m_push   = 1;
          m_latest = ch_data;
        end
        if (rel && round_done) pend.push_back(t_ce + DELAY);
        if (t_ce == HOLD) rel = 1;
      end
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        if (q.size() < DEPTH) q.push_back(ch_data);
        else begin
          m_ovf = 1;
          if (m_ovfc < 65535) m_ovfc++;
        end
      end
    end
  end

  int     n_ovf_seen = 0;
  bit     log_pops = 0;
  frame_t popped[$];

  always @(negedge CLK) begin
    chk("sensor_rst_n", 64'(sensor_rst_n), 64'(rel));
    chk("latest", 64'(latest), 64'(m_latest));
    chk("frame_valid", 64'(frame_valid), 64'(q.size() > 0));
    chk("fill_level", 64'(fill_level), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (q.size() > 0) chk("frame_data", 64'(frame_data), 64'(q[0]));
`ifdef SENSOR_FIFO_STATS_EN
    chk("ovf_count", 64'(ovf_count), 64'(m_ovfc));
`endif
    if (overflow) n_ovf_seen++;
    if (log_pops && frame_valid && frame_ready) popped.push_back(frame_data);
  end

  // One ce period: nine idle clocks then the ce clock; returns 1 time unit after the ce edge.
  task automatic tick(input bit rd, input bit rdy_ce);
    ce = 0; round_done = 0; frame_ready = 0;
    repeat (9) begin @(posedge CLK); #1; end
    ce = 1; round_done = rd; frame_ready = rdy_ce;
    @(posedge CLK); #1;
    ce = 0; round_done = 0; frame_ready = 0;
  endtask

  task automatic check_hold();
    for (int i = 1; i <= HOLD; i++) begin
      tick(i >= 60, 0);
      if (i == HOLD - 1) chk("hold_before_last", 64'(sensor_rst_n), 64'd0);
      if (i == HOLD)     chk("hold_release", 64'(sensor_rst_n), 64'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_sensor_rst_n", 64'(sensor_rst_n), 64'd0);
    chk("rst_fill_level", 64'(fill_level), 64'd0);
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    RST = 1;

    // Hold release; round_done during the hold must not capture.
    check_hold();
    repeat (3) tick(0, 0);
    chk("hold_no_capture", 64'(fill_level), 64'd0);

    // First capture three ticks after round_done.
    ch_data = 36'h123_456_789;
    tick(1, 0); tick(0, 0); tick(0, 0);
    chk("latest_before_cap", 64'(latest), 64'd0);
    tick(0, 0);
    chk("latest_cap", 64'(latest), 64'h1_2345_6789);
    chk("valid_after_cap", 64'(frame_valid), 64'd1);
    chk("fill_after_cap", 64'(fill_level), 64'd1);
    frame_ready = 1; @(posedge CLK); #1; frame_ready = 0;
    chk("fill_after_pop", 64'(fill_level), 64'd0);

    // Five captures into a 4-deep FIFO.
    base = n_ovf_seen;
    for (int i = 0; i < 8; i++) begin
      ch_data = (i >= 3) ? frames[i-3] : '0;
      tick(i < 5, 0);
    end
    @(negedge CLK); #1;
    chk("full_fill", 64'(fill_level), 64'd4);
    chk("full_head", 64'(frame_data), 64'h001_002_003);
    chk("full_latest", 64'(latest), 64'h041_042_043);
    chk("ovf_pulses", 64'(n_ovf_seen - base), 64'd1);
`ifdef SENSOR_FIFO_STATS_EN
    chk("ovf_count_1", 64'(ovf_count), 64'd1);
`endif

    // Full FIFO: push and pop on the same edge.
    base = n_ovf_seen;
    tick(1, 0); tick(0, 0); tick(0, 0);
    ch_data = frames[5];
    tick(0, 1);
    @(negedge CLK); #1;
    chk("pushpop_fill", 64'(fill_level), 64'd4);
    chk("pushpop_head", 64'(frame_data), 64'h011_012_013);
    chk("pushpop_no_ovf", 64'(n_ovf_seen - base), 64'd0);
    frame_ready = 1; repeat (4) begin @(posedge CLK); #1; end frame_ready = 0;
    chk("drained", 64'(fill_level), 64'd0);

    // Stream ten frames with random ready; pointers wrap.
    popped.delete();
    log_pops = 1;
    for (int i = 0; i < 13; i++) begin
      ch_data = (i >= 3) ? frames[i-3] : '0;
      for (int c = 0; c < 10; c++) begin
        ce = (c == 9); round_done = (c == 9) && (i < 10);
        frame_ready = ($urandom_range(0, 3) == 0);
        @(posedge CLK); #1;
      end
    end
    ce = 0; round_done = 0;
    frame_ready = 1; repeat (6) begin @(posedge CLK); #1; end frame_ready = 0;
    @(negedge CLK); #1;
    log_pops = 0;
    chk("stream_count", 64'(popped.size()), 64'd10);
    for (int j = 0; j < 10 && j < popped.size(); j++)
      chk("stream_order", 64'(popped[j]), 64'(frames[j]));

    // Asynchronous reset mid-stream with three frames stored.
    for (int i = 0; i < 6; i++) begin
      ch_data = frames[i];
      tick(i < 3, 0);
    end
    chk("pre_rst_fill", 64'(fill_level), 64'd3);
    #3 RST = 0;
    #1;
    chk("arst_fill", 64'(fill_level), 64'd0);
    chk("arst_valid", 64'(frame_valid), 64'd0);
    chk("arst_latest", 64'(latest), 64'd0);
    chk("arst_sensor", 64'(sensor_rst_n), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1;
    check_hold();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
